// File: rtl/operand_stage.sv
// RV32I decode/operand-fetch stage: latches one instruction, reads the 32x32
// register file with writeback forwarding, and presents ALU operands under valid/ready.
module operand_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [6:0]      opcode,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] rs2_data,
  output logic [4:0]      rd,
  output logic            illegal,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_VALID} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_rf [32];
  logic [31:0] r_instr, r_pc;

  logic [31:0] r_op1, r_op2, r_imm, r_rs2_data;
  logic [6:0]  r_opcode, r_func7;
  logic [2:0]  r_func3;
  logic [4:0]  r_rd;
  logic        r_illegal;

  logic [4:0]  w_rs1_addr, w_rs2_addr;
  logic [31:0] w_rs1, w_rs2;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_op1, w_op2, w_imm;
  logic [6:0]  w_func7;
  logic        w_illegal;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (instr_valid) w_next = S_READ;
      S_READ:  w_next = S_VALID;
      S_VALID: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // x0 is never written, so it reads 0 without a dedicated mux.
  always_ff @(posedge clk) begin
    if (!rst_n)                        r_rf <= '{default: '0};
    else if (wb_en && wb_rd != 5'd0)   r_rf[wb_rd] <= wb_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instr <= '0;
      r_pc    <= '0;
    end else if (r_state == S_IDLE && instr_valid) begin
      r_instr <= instr;
      r_pc    <= pc;
    end
  end

  assign w_rs1_addr = r_instr[19:15];
  assign w_rs2_addr = r_instr[24:20];
  assign w_rs1 = (wb_en && wb_rd == w_rs1_addr && w_rs1_addr != 5'd0) ? wb_data : r_rf[w_rs1_addr];
  assign w_rs2 = (wb_en && wb_rd == w_rs2_addr && w_rs2_addr != 5'd0) ? wb_data : r_rf[w_rs2_addr];

  assign w_imm_i = {{20{r_instr[31]}}, r_instr[31:20]};
  assign w_imm_s = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
  assign w_imm_b = {{19{r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0};
  assign w_imm_u = {r_instr[31:12], 12'b0};
  assign w_imm_j = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0};

  always_comb begin
    w_op1     = '0;
    w_op2     = '0;
    w_imm     = '0;
    w_func7   = '0;
    w_illegal = 1'b0;
    case (r_instr[6:0])
      OP_R: begin
        w_op1   = w_rs1;
        w_op2   = w_rs2;
        w_func7 = r_instr[31:25];
      end
      OP_IALU, OP_LOAD, OP_JALR: begin
        w_op1 = w_rs1;
        w_op2 = w_imm_i;
        w_imm = w_imm_i;
        if (r_instr[6:0] == OP_IALU && r_instr[13:12] == 2'b01) w_func7 = r_instr[31:25];
      end
      OP_STORE: begin
        w_op1 = w_rs1;
        w_op2 = w_imm_s;
        w_imm = w_imm_s;
      end
      OP_BRANCH: begin
        w_op1 = w_rs1;
        w_op2 = w_rs2;
        w_imm = w_imm_b;
      end
      OP_LUI: begin
        w_op2 = w_imm_u;
        w_imm = w_imm_u;
      end
      OP_AUIPC: begin
        w_op1 = r_pc;
        w_op2 = w_imm_u;
        w_imm = w_imm_u;
      end
      OP_JAL: begin
        w_op1 = r_pc;
        w_op2 = 32'd4;
        w_imm = w_imm_j;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_opcode   <= '0;
      r_func3    <= '0;
      r_func7    <= '0;
      r_op1      <= '0;
      r_op2      <= '0;
      r_imm      <= '0;
      r_rs2_data <= '0;
      r_rd       <= '0;
      r_illegal  <= 1'b0;
    end else if (r_state == S_READ) begin
      r_opcode   <= r_instr[6:0];
      r_func3    <= r_instr[14:12];
      r_func7    <= w_func7;
      r_op1      <= w_op1;
      r_op2      <= w_op2;
      r_imm      <= w_imm;
      r_rs2_data <= w_rs2;
      r_rd       <= r_instr[11:7];
      r_illegal  <= w_illegal;
    end
  end

  assign instr_ready = (r_state == S_IDLE) && rst_n;
  assign out_valid   = (r_state == S_VALID);
  assign opcode      = r_opcode;
  assign func3       = r_func3;
  assign func7       = r_func7;
  assign op1         = r_op1;
  assign op2         = r_op2;
  assign imm         = r_imm;
  assign rs2_data    = r_rs2_data;
  assign rd          = r_rd;
  assign illegal     = r_illegal;

endmodule

// File: tb/tb_operand_stage.sv
// Directed self-checking bench for operand_stage with hand-computed expectations.
module tb_operand_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr, pc;
  logic        instr_valid, instr_ready;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [6:0]  opcode, func7;
  logic [2:0]  func3;
  logic [31:0] op1, op2, imm, rs2_data;
  logic [4:0]  rd;
  logic        illegal, out_valid, out_ready;

  int n_total = 0;
  int n_bad   = 0;

  operand_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .pc(pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .opcode(opcode), .func3(func3), .func7(func7),
    .op1(op1), .op2(op2), .imm(imm), .rs2_data(rs2_data), .rd(rd),
    .illegal(illegal), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    wb_en = 1'b1; wb_rd = r; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  // Accept, then one READ cycle with optional writeback, landing in VALID.
  task automatic issue(input logic [31:0] ins, input logic [31:0] p,
                       input logic fen, input logic [4:0] frd, input logic [31:0] fdat);
    int unsigned k = 0;
    while (!instr_ready && k < 20) begin
      tick();
      k++;
    end
    check("ready_before_issue", {31'd0, instr_ready}, 32'd1);
    instr = ins; pc = p; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    check("read_out_valid", {31'd0, out_valid}, 32'd0);
    check("read_instr_ready", {31'd0, instr_ready}, 32'd0);
    wb_en = fen; wb_rd = frd; wb_data = fdat;
    tick();
    wb_en = 1'b0;
    check("valid_out_valid", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("consume_out_valid", {31'd0, out_valid}, 32'd0);
    check("consume_instr_ready", {31'd0, instr_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; instr = '0; pc = '0; instr_valid = 1'b0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b0;
    tick();
    tick();
    check("rst_instr_ready", {31'd0, instr_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_op1", op1, 32'd0);
    check("rst_op2", op2, 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", {31'd0, instr_ready}, 32'd1);

    // or x4,x2,x3
    wb_write(5'd2, 32'h33);
    wb_write(5'd3, 32'h0A);
    issue(32'h00316233, 32'h0, 1'b0, 5'd0, 32'h0);
    check("or_opcode", {25'd0, opcode}, 32'h33);
    check("or_func3", {29'd0, func3}, 32'd6);
    check("or_func7", {25'd0, func7}, 32'd0);
    check("or_op1", op1, 32'h33);
    check("or_op2", op2, 32'h0A);
    check("or_rd", {27'd0, rd}, 32'd4);
    check("or_rs2", rs2_data, 32'h0A);
    check("or_illegal", {31'd0, illegal}, 32'd0);
    consume();

    // addi x1,x0,-1
    issue(32'hFFF00093, 32'h4, 1'b0, 5'd0, 32'h0);
    check("addi_op1", op1, 32'h0);
    check("addi_op2", op2, 32'hFFFFFFFF);
    check("addi_imm", imm, 32'hFFFFFFFF);
    check("addi_func7", {25'd0, func7}, 32'd0);
    consume();

    // srai x6,x7,3
    wb_write(5'd7, 32'h80000000);
    issue(32'h4033D313, 32'h8, 1'b0, 5'd0, 32'h0);
    check("srai_func3", {29'd0, func3}, 32'd5);
    check("srai_func7", {25'd0, func7}, 32'h20);
    check("srai_op1", op1, 32'h80000000);
    check("srai_op2", op2, 32'h00000403);
    consume();

    // lui / auipc x5,0x12345
    issue(32'h123452B7, 32'h100, 1'b0, 5'd0, 32'h0);
    check("lui_op1", op1, 32'h0);
    check("lui_op2", op2, 32'h12345000);
    check("lui_rd", {27'd0, rd}, 32'd5);
    consume();
    issue(32'h12345297, 32'h100, 1'b0, 5'd0, 32'h0);
    check("auipc_op1", op1, 32'h100);
    check("auipc_op2", op2, 32'h12345000);
    consume();

    // jal x1,8
    issue(32'h008000EF, 32'h200, 1'b0, 5'd0, 32'h0);
    check("jal_op1", op1, 32'h200);
    check("jal_op2", op2, 32'd4);
    check("jal_imm", imm, 32'd8);
    consume();

    // forwarding in READ, then snapshot while stalled with instr_valid ignored
    issue(32'h00316233, 32'h0, 1'b1, 5'd2, 32'h77);
    check("fwd_op1", op1, 32'h77);
    check("fwd_op2", op2, 32'h0A);
    instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h55;
      end
      tick();
      wb_en = 1'b0;
      check("hold_op2", op2, 32'h0A);
      check("hold_rs2", rs2_data, 32'h0A);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_instr_ready", {31'd0, instr_ready}, 32'd0);
    end
    instr_valid = 1'b0;
    consume();

    // sw x3,-8(x2): sees x3 written during the stall
    issue(32'hFE312C23, 32'h0, 1'b0, 5'd0, 32'h0);
    check("sw_op1", op1, 32'h77);
    check("sw_op2", op2, 32'hFFFFFFF8);
    check("sw_rs2", rs2_data, 32'h55);
    consume();

    // beq x2,x3,-16
    issue(32'hFE3108E3, 32'h0, 1'b0, 5'd0, 32'h0);
    check("beq_op1", op1, 32'h77);
    check("beq_op2", op2, 32'h55);
    check("beq_imm", imm, 32'hFFFFFFF0);
    consume();

    // reset during VALID
    issue(32'h00316233, 32'h0, 1'b0, 5'd0, 32'h0);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_instr_ready", {31'd0, instr_ready}, 32'd0);
    end
    rst_n = 1'b1;
    #1;
    check("midrst_ready_after", {31'd0, instr_ready}, 32'd1);
    issue(32'h00316233, 32'h0, 1'b0, 5'd0, 32'h0);
    check("postrst_x2", op1, 32'h0);
    check("postrst_x3", op2, 32'h0);
    consume();

    // illegal opcode still handshakes
    issue(32'h0000007F, 32'h40, 1'b0, 5'd0, 32'h0);
    check("ill_flag", {31'd0, illegal}, 32'd1);
    check("ill_op1", op1, 32'h0);
    check("ill_op2", op2, 32'h0);
    check("ill_imm", imm, 32'h0);
    consume();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
